dds_sweep_ctrl: RTL

//  Frequency-sweep sequencer directly upstream of dds; drives its sin_fre_word/tri_*_word inputs.

---
 rtl/dds_pkg.sv | 39 +++
 rtl/dds_dwell_timer.sv | 32 +++
 rtl/dds_sweep_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// Shared types for the DDS frequency-sweep sequencer.
// The DOWN state and the bidir shadow bit exist only when DDS_SWEEP_BIDIR_EN is defined.
package dds_pkg;

  localparam int unsigned DDS_FW = 32;
  localparam int unsigned DDS_CW = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UP   = 3'd1,
    ST_LAST = 3'd2,
`ifdef DDS_SWEEP_BIDIR_EN
    ST_DOWN = 3'd3,
`endif
    ST_FIN  = 3'd4
  } sweep_state_e;

  // Snapshot of the configuration taken when a sweep starts
  typedef struct packed {
    logic [DDS_FW-1:0] start_word;
    logic [DDS_FW-1:0] stop_word;
    logic [DDS_FW-1:0] step_word;
    logic [DDS_CW-1:0] dwell;
    logic              mode_cont;
    logic              single;
`ifdef DDS_SWEEP_BIDIR_EN
    logic              bidir;
`endif
  } sweep_cfg_t;

  function automatic logic [DDS_CW-1:0] dwell_norm(input logic [DDS_CW-1:0] d);
    if (d == {DDS_CW{1'b0}}) begin
      return {{(DDS_CW-1){1'b0}}, 1'b1};
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/dds_dwell_timer.sv
// Per-point dwell down-counter; expire is high while the count sits at zero.
// Loading (dwell-1) yields exactly dwell clocks from load to the next load.
module dds_dwell_timer
  import dds_pkg::*;
#(
  parameter int unsigned CW = DDS_CW
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          expire
);

  logic [CW-1:0] cnt_r;

  // Dwell counter: reload on every word load, otherwise count down to zero and hold
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {CW{1'b0}}) begin
      cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer feeding the dds frequency word with start/abort and busy/done status.
// Define DDS_SWEEP_BIDIR_EN to add the up-then-down (DOWN state) sweep; otherwise bidir is ignored and dir is 0.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int unsigned FW = DDS_FW,
  parameter int unsigned CW = DDS_CW
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          mode_cont,
  input  logic          bidir,
  input  logic [FW-1:0] start_word,
  input  logic [FW-1:0] stop_word,
  input  logic [FW-1:0] step_word,
  input  logic [CW-1:0] dwell_cycles,
  output logic [FW-1:0] fre_word,
  output logic          fre_valid,
  output logic          busy,
  output logic          done,
  output logic          dir
);

  localparam logic [CW-1:0] ONE_CW = {{(CW-1){1'b0}}, 1'b1};

  sweep_state_e  state_r, state_nx;
  sweep_cfg_t    cfg_r, cfg_nx;
  logic [FW-1:0] fre_word_r, word_nx;
  logic          fre_valid_r, valid_nx;
  logic          busy_r, busy_nx;
  logic          done_r, done_nx;
  logic          dir_r, dir_nx;
  logic          timer_load_s;
  logic [CW-1:0] timer_val_s;
  logic          expire_s;
  logic [FW:0]   sum_s;
  logic          hit_stop_s;

  // Extra bit keeps the carry so a sweep near the top of the range clamps instead of wrapping
  assign sum_s      = {1'b0, fre_word_r} + {1'b0, cfg_r.step_word};
  assign hit_stop_s = (sum_s >= {1'b0, cfg_r.stop_word});

`ifdef DDS_SWEEP_BIDIR_EN
  logic [FW:0] diff_s;
  logic        hit_start_s;
  assign diff_s      = {1'b0, fre_word_r} - {1'b0, cfg_r.step_word};
  assign hit_start_s = diff_s[FW] || (diff_s[FW-1:0] <= cfg_r.start_word);
`else
  logic unused_bidir_s;
  assign unused_bidir_s = bidir;
`endif

  dds_dwell_timer #(.CW(CW)) u_dwell (
    .clock    (clock),
    .rst      (rst),
    .load     (timer_load_s),
    .load_val (timer_val_s),
    .expire   (expire_s)
  );

  // State register plus registered outputs and shadow configuration
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cfg_r       <= {$bits(sweep_cfg_t){1'b0}};
      fre_word_r  <= {FW{1'b0}};
      fre_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dir_r       <= 1'b0;
    end else begin
      state_r     <= state_nx;
      cfg_r       <= cfg_nx;
      fre_word_r  <= word_nx;
      fre_valid_r <= valid_nx;
      busy_r      <= busy_nx;
      done_r      <= done_nx;
      dir_r       <= dir_nx;
    end
  end

  // Next-state, next word and dwell reload decisions
  always_comb begin
    state_nx     = state_r;
    cfg_nx       = cfg_r;
    word_nx      = fre_word_r;
    valid_nx     = 1'b0;
    timer_load_s = 1'b0;
    timer_val_s  = cfg_r.dwell - ONE_CW;
    if (abort && (state_r != ST_IDLE)) begin
      state_nx = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && !abort) begin
            cfg_nx.start_word = start_word;
            cfg_nx.stop_word  = stop_word;
            cfg_nx.step_word  = step_word;
            cfg_nx.dwell      = dwell_norm(dwell_cycles);
            cfg_nx.mode_cont  = mode_cont;
            cfg_nx.single     = (start_word >= stop_word) || (step_word == {FW{1'b0}});
`ifdef DDS_SWEEP_BIDIR_EN
            cfg_nx.bidir      = bidir;
`endif
            word_nx      = start_word;
            valid_nx     = 1'b1;
            timer_load_s = 1'b1;
            timer_val_s  = dwell_norm(dwell_cycles) - ONE_CW;
            state_nx     = ST_UP;
          end else begin
            state_nx = ST_IDLE;
          end
        end
        ST_UP: begin
          if (!expire_s) begin
            state_nx = ST_UP;
          end else if (cfg_r.single) begin
            state_nx = ST_FIN;
          end else begin
            valid_nx     = 1'b1;
            timer_load_s = 1'b1;
            if (hit_stop_s) begin
              word_nx  = cfg_r.stop_word;
              state_nx = ST_LAST;
            end else begin
              word_nx  = sum_s[FW-1:0];
              state_nx = ST_UP;
            end
          end
        end
        ST_LAST: begin
          if (!expire_s) begin
            state_nx = ST_LAST;
          end
`ifdef DDS_SWEEP_BIDIR_EN
          else if (cfg_r.bidir) begin
            valid_nx     = 1'b1;
            timer_load_s = 1'b1;
            word_nx      = hit_start_s ? cfg_r.start_word : diff_s[FW-1:0];
            state_nx     = ST_DOWN;
          end
`endif
          else if (cfg_r.mode_cont) begin
            valid_nx     = 1'b1;
            timer_load_s = 1'b1;
            word_nx      = cfg_r.start_word;
            state_nx     = ST_UP;
          end else begin
            state_nx = ST_FIN;
          end
        end
`ifdef DDS_SWEEP_BIDIR_EN
        ST_DOWN: begin
          if (!expire_s) begin
            state_nx = ST_DOWN;
          end else if (fre_word_r <= cfg_r.start_word) begin
            // Bottom point has been held: either climb again or finish
            if (cfg_r.mode_cont) begin
              valid_nx     = 1'b1;
              timer_load_s = 1'b1;
              if (hit_stop_s) begin
                word_nx  = cfg_r.stop_word;
                state_nx = ST_LAST;
              end else begin
                word_nx  = sum_s[FW-1:0];
                state_nx = ST_UP;
              end
            end else begin
              state_nx = ST_FIN;
            end
          end else begin
            valid_nx     = 1'b1;
            timer_load_s = 1'b1;
            word_nx      = hit_start_s ? cfg_r.start_word : diff_s[FW-1:0];
            state_nx     = ST_DOWN;
          end
        end
`endif
        ST_FIN: begin
          state_nx = ST_IDLE;
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end
`ifdef DDS_SWEEP_BIDIR_EN
    busy_nx = (state_nx == ST_UP) || (state_nx == ST_LAST) || (state_nx == ST_DOWN);
    dir_nx  = (state_nx == ST_DOWN);
`else
    busy_nx = (state_nx == ST_UP) || (state_nx == ST_LAST);
    dir_nx  = 1'b0;
`endif
    done_nx = (state_nx == ST_FIN);
  end

  assign fre_word  = fre_word_r;
  assign fre_valid = fre_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign dir       = dir_r;

endmodule
